mem_access: RTL and testbench



---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-bus port bundle for the ME stage.
// Request side is driven by the stage, response side by memory.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access.sv
// RV32 memory-access stage: bus handshake, lane steering,
// load extraction and pass-through of non-memory results.
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] st_data_i,
    input  logic        rd_we_i,
    input  logic [4:0]  rd_waddr_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    mem_access_if.master dbus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic              rd_we_q, rd_we_d;
    logic [4:0]        rd_waddr_q, rd_waddr_d;

    logic              is_mem;
    logic              mis_in;
    logic [ADDR_W-1:0] addr_in;
    logic [3:0]        be_in;
    logic [31:0]       wdata_in;
    logic [31:0]       ld_sh;
    logic [31:0]       ld_data;
    logic              tmo;

    assign is_mem  = valid_i & (mem_rd_i | mem_wr_i);
    assign addr_in = {alu_res_i[ADDR_W-1:2], 2'b00};
    assign tmo     = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));
    assign ld_sh   = dbus.rdata >> {addr_q[1:0], 3'b000};

    // Access size decode: alignment, byte enables, lane-replicated data
    always_comb begin
        mis_in   = 1'b0;
        be_in    = 4'b1111;
        wdata_in = st_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << alu_res_i[1:0];
                wdata_in = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                mis_in   = alu_res_i[0];
                be_in    = alu_res_i[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{st_data_i[15:0]}};
            end
            default: begin
                mis_in = |alu_res_i[1:0];
            end
        endcase
    end

    // Load extraction from the lane latched at request time
    always_comb begin
        ld_data = dbus.rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'b001:  ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'b100:  ld_data = {24'd0, ld_sh[7:0]};
            3'b101:  ld_data = {16'd0, ld_sh[15:0]};
            default: ld_data = dbus.rdata;
        endcase
    end

    // Handshake FSM, next-state and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rd_we_d    = rd_we_q;
        rd_waddr_d = rd_waddr_q;
        dbus.req   = 1'b0;
        dbus.we    = we_q;
        dbus.addr  = addr_q;
        dbus.be    = be_q;
        dbus.wdata = wdata_q;
        rd_we_o    = 1'b0;
        rd_waddr_o = rd_waddr_i;
        rd_data_o  = alu_res_i;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        bus_err_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i && !is_mem) begin
                    rd_we_o = rd_we_i;
                end else if (is_mem && mis_in) begin
                    misalign_o = 1'b1;
                end else if (is_mem) begin
                    dbus.req   = 1'b1;
                    dbus.we    = mem_wr_i;
                    dbus.addr  = addr_in;
                    dbus.be    = be_in;
                    dbus.wdata = wdata_in;
                    addr_d     = alu_res_i[ADDR_W-1:0];
                    be_d       = be_in;
                    wdata_d    = wdata_in;
                    we_d       = mem_wr_i;
                    f3_d       = funct3_i;
                    rd_we_d    = rd_we_i;
                    rd_waddr_d = rd_waddr_i;
                    cnt_d      = '0;
                    if (dbus.gnt && mem_wr_i) begin
                        state_d = S_IDLE;
                    end else if (dbus.gnt) begin
                        state_d = S_WAIT;
                        stall_o = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        stall_o = 1'b1;
                    end
                end
            end
            S_REQ: begin
                dbus.req  = 1'b1;
                dbus.addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (dbus.gnt && we_q) begin
                    state_d = S_IDLE;
                end else if (dbus.gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    stall_o = 1'b1;
                end else if (tmo) begin
                    state_d   = S_IDLE;
                    bus_err_o = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    stall_o = 1'b1;
                end
            end
            S_WAIT: begin
                rd_waddr_o = rd_waddr_q;
                if (dbus.rvalid) begin
                    rd_data_o = ld_data;
                    rd_we_o   = rd_we_q & (|rd_waddr_q);
                    state_d   = S_IDLE;
                end else if (tmo) begin
                    state_d   = S_IDLE;
                    bus_err_o = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    stall_o = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            dbus.req   = 1'b0;
            rd_we_o    = 1'b0;
            stall_o    = 1'b0;
            misalign_o = 1'b0;
            bus_err_o  = 1'b0;
        end
        if (!valid_i && state_q == S_IDLE) begin
            rd_we_o = 1'b0;
        end
    end

    // State, timeout counter and latched access fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rd_we_q    <= rd_we_d;
            rd_waddr_q <= rd_waddr_d;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for the ME stage: pass-through, stores,
// loads, misalignment, timeout and reset during a load.
module tb_mem_access;
    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_res_i;
    logic [31:0] st_data_i;
    logic        rd_we_i;
    logic [4:0]  rd_waddr_i;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_data_o;
    logic        stall_o;
    logic        misalign_o;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;
    int n;
    int reqs;
    logic seen;

    mem_access_if #(.ADDR_W(32)) dbus ();

    mem_access #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .mem_rd_i   (mem_rd_i),
        .mem_wr_i   (mem_wr_i),
        .funct3_i   (funct3_i),
        .alu_res_i  (alu_res_i),
        .st_data_i  (st_data_i),
        .rd_we_i    (rd_we_i),
        .rd_waddr_i (rd_waddr_i),
        .rd_we_o    (rd_we_o),
        .rd_waddr_o (rd_waddr_o),
        .rd_data_o  (rd_data_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .bus_err_o  (bus_err_o),
        .dbus       (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        valid_i    = 1'b0;
        mem_rd_i   = 1'b0;
        mem_wr_i   = 1'b0;
        funct3_i   = 3'b000;
        alu_res_i  = '0;
        st_data_i  = '0;
        rd_we_i    = 1'b0;
        rd_waddr_i = '0;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b0;
        dbus.rdata  = '0;
    endtask

    task automatic mem_in(input logic ld, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd);
        valid_i    = 1'b1;
        mem_rd_i   = ld;
        mem_wr_i   = ~ld;
        funct3_i   = f3;
        alu_res_i  = a;
        st_data_i  = d;
        rd_we_i    = ld;
        rd_waddr_i = rd;
    endtask

    task automatic load_run(input logic [2:0] f3, input string tag,
                            input logic [31:0] exp);
        @(negedge clk);
        mem_in(1'b1, f3, 32'h102, 32'h0, 5'd7);
        dbus.gnt = 1'b1;
        #1 chk({tag, "_req"}, {31'd0, dbus.req}, 32'd1);
        chk({tag, "_stall0"}, {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        dbus.gnt = 1'b0;
        #1 chk({tag, "_wait_req"}, {31'd0, dbus.req}, 32'd0);
        chk({tag, "_stall1"}, {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h0080_0000;
        #1 chk({tag, "_data"}, rd_data_o, exp);
        chk({tag, "_we"}, {31'd0, rd_we_o}, 32'd1);
        chk({tag, "_waddr"}, {27'd0, rd_waddr_o}, 32'd7);
        chk({tag, "_stall2"}, {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_req", {31'd0, dbus.req}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_we", {31'd0, rd_we_o}, 32'd0);
        chk("rst_mis", {31'd0, misalign_o}, 32'd0);
        chk("rst_err", {31'd0, bus_err_o}, 32'd0);

        // ALU pass-through
        @(negedge clk);
        valid_i    = 1'b1;
        alu_res_i  = 32'h1234;
        rd_we_i    = 1'b1;
        rd_waddr_i = 5'd5;
        #1 chk("alu_data", rd_data_o, 32'h1234);
        chk("alu_we", {31'd0, rd_we_o}, 32'd1);
        chk("alu_waddr", {27'd0, rd_waddr_o}, 32'd5);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        chk("alu_req", {31'd0, dbus.req}, 32'd0);

        // Invalid instruction never writes back
        @(negedge clk);
        valid_i = 1'b0;
        #1 chk("inv_we", {31'd0, rd_we_o}, 32'd0);

        // SB with gnt held low for 3 cycles
        @(negedge clk);
        mem_in(1'b0, 3'b000, 32'h103, 32'hAB, 5'd0);
        reqs = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("sb_be", {28'd0, dbus.be}, 32'h8);
            chk("sb_wdata", dbus.wdata, 32'hABAB_ABAB);
            chk("sb_stall", {31'd0, stall_o}, 32'd1);
            if (dbus.req) reqs++;
            @(negedge clk);
            st_data_i = 32'h5555_5555;
        end
        dbus.gnt = 1'b1;
        #1 chk("sb_addr", dbus.addr, 32'h100);
        chk("sb_we", {31'd0, dbus.we}, 32'd1);
        chk("sb_wdata_held", dbus.wdata, 32'hABAB_ABAB);
        chk("sb_done_stall", {31'd0, stall_o}, 32'd0);
        chk("sb_done_rdwe", {31'd0, rd_we_o}, 32'd0);
        if (dbus.req) reqs++;
        chk("sb_req_cycles", reqs, 32'd4);
        @(negedge clk);
        idle_in();
        #1 chk("sb_after_req", {31'd0, dbus.req}, 32'd0);

        // LB / LBU from lane 2
        load_run(3'b000, "lb", 32'hFFFF_FF80);
        load_run(3'b100, "lbu", 32'h0000_0080);

        // Misaligned LW
        @(negedge clk);
        mem_in(1'b1, 3'b010, 32'h102, 32'h0, 5'd4);
        #1 chk("mis_pulse", {31'd0, misalign_o}, 32'd1);
        chk("mis_req", {31'd0, dbus.req}, 32'd0);
        chk("mis_we", {31'd0, rd_we_o}, 32'd0);
        chk("mis_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        idle_in();
        #1 chk("mis_clear", {31'd0, misalign_o}, 32'd0);

        // SH upper half, granted at once
        @(negedge clk);
        mem_in(1'b0, 3'b001, 32'h102, 32'h1234_ABCD, 5'd0);
        dbus.gnt = 1'b1;
        #1 chk("sh_be", {28'd0, dbus.be}, 32'hC);
        chk("sh_wdata", dbus.wdata, 32'hABCD_ABCD);
        chk("sh_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        mem_in(1'b0, 3'b010, 32'h104, 32'hCAFE_F00D, 5'd0);
        #1 chk("sw_be", {28'd0, dbus.be}, 32'hF);
        chk("sw_wdata", dbus.wdata, 32'hCAFE_F00D);
        chk("sw_addr", dbus.addr, 32'h104);
        @(negedge clk);
        idle_in();

        // LH with no rvalid: timeout abort
        @(negedge clk);
        mem_in(1'b1, 3'b001, 32'h100, 32'h0, 5'd6);
        dbus.gnt = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus_err_o) begin
                seen = 1'b1;
                break;
            end
            if (stall_o) n++;
            @(negedge clk);
            dbus.gnt = 1'b0;
        end
        chk("tmo_seen", {31'd0, seen}, 32'd1);
        chk("tmo_stall_cycles", n, 32'd9);
        chk("tmo_stall_drop", {31'd0, stall_o}, 32'd0);
        chk("tmo_we", {31'd0, rd_we_o}, 32'd0);
        @(negedge clk);
        idle_in();
        #1 chk("tmo_pulse_end", {31'd0, bus_err_o}, 32'd0);

        // Reset while waiting; late rvalid ignored
        @(negedge clk);
        mem_in(1'b1, 3'b010, 32'h104, 32'h0, 5'd3);
        dbus.gnt = 1'b1;
        @(negedge clk);
        dbus.gnt = 1'b0;
        #1 chk("rw_wait_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rw_rst_req", {31'd0, dbus.req}, 32'd0);
        chk("rw_rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_in();
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'hDEAD_BEEF;
        #1 chk("rw_late_we", {31'd0, rd_we_o}, 32'd0);
        chk("rw_late_stall", {31'd0, stall_o}, 32'd0);
        chk("rw_late_req", {31'd0, dbus.req}, 32'd0);
        @(negedge clk);
        idle_in();

        // LW to x0: access happens, no writeback
        @(negedge clk);
        mem_in(1'b1, 3'b010, 32'h108, 32'h0, 5'd0);
        dbus.gnt = 1'b1;
        #1 chk("x0_req", {31'd0, dbus.req}, 32'd1);
        @(negedge clk);
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h1122_3344;
        #1 chk("x0_data", rd_data_o, 32'h1122_3344);
        chk("x0_we", {31'd0, rd_we_o}, 32'd0);
        chk("x0_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        idle_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
